// File: rtl/datacache_pkg.sv
// Shared geometry, FSM state encoding and line word-access helpers for the
// direct-mapped write-back data cache.
package datacache_pkg;

    localparam int WORD_SIZE        = 32;
    localparam int BLOCK_SIZE       = 256;
    localparam int BYTE_SIZE        = 8;
    localparam int CACHE_GROUP      = 8;
    localparam int CACHE_OFFSET_LEN = 5;
    localparam int CACHE_INDEX_LEN  = 3;
    localparam int CACHE_TAG_LEN    = 24;
    localparam int WORD_SEL_LEN     = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WBACK  = 2'd1,
        ST_REFILL = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    function automatic logic [WORD_SIZE-1:0] line_word(
        input logic [BLOCK_SIZE-1:0]   line,
        input logic [WORD_SEL_LEN-1:0] sel
    );
        return line[sel*WORD_SIZE +: WORD_SIZE];
    endfunction

    function automatic logic [BLOCK_SIZE-1:0] line_merge(
        input logic [BLOCK_SIZE-1:0]   line,
        input logic [WORD_SEL_LEN-1:0] sel,
        input logic [WORD_SIZE-1:0]    data
    );
        logic [BLOCK_SIZE-1:0] merged;
        merged = line;
        merged[sel*WORD_SIZE +: WORD_SIZE] = data;
        return merged;
    endfunction

endpackage

// File: rtl/datacache_array.sv
// Line storage for the data cache: Valid/Dirty/Tag/Data per line, one
// asynchronous read port, a whole-line fill port and a word-write port.
module datacache_array #(
    parameter int LINES = datacache_pkg::CACHE_GROUP
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [datacache_pkg::CACHE_INDEX_LEN-1:0]  rd_index,
    output logic                                       rd_valid,
    output logic                                       rd_dirty,
    output logic [datacache_pkg::CACHE_TAG_LEN-1:0]    rd_tag,
    output logic [datacache_pkg::BLOCK_SIZE-1:0]       rd_data,
    input  logic                                       fill_en,
    input  logic [datacache_pkg::CACHE_INDEX_LEN-1:0]  fill_index,
    input  logic [datacache_pkg::CACHE_TAG_LEN-1:0]    fill_tag,
    input  logic [datacache_pkg::BLOCK_SIZE-1:0]       fill_data,
    input  logic                                       wr_en,
    input  logic [datacache_pkg::CACHE_INDEX_LEN-1:0]  wr_index,
    input  logic [datacache_pkg::WORD_SEL_LEN-1:0]     wr_word,
    input  logic [datacache_pkg::WORD_SIZE-1:0]        wr_data
);
    import datacache_pkg::*;

    logic [LINES-1:0]         valid_q, valid_d;
    logic [LINES-1:0]         dirty_q, dirty_d;
    logic [CACHE_TAG_LEN-1:0] tag_q  [LINES];
    logic [CACHE_TAG_LEN-1:0] tag_d  [LINES];
    logic [BLOCK_SIZE-1:0]    data_q [LINES];
    logic [BLOCK_SIZE-1:0]    data_d [LINES];

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

    // Next-state of the storage: a refill replaces the whole line, a store merges one word.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[fill_index] = 1'b1;
            dirty_d[fill_index] = 1'b0;
            tag_d[fill_index]   = fill_tag;
            data_d[fill_index]  = fill_data;
        end else if (wr_en) begin
            dirty_d[wr_index] = 1'b1;
            data_d[wr_index]  = line_merge(data_q[wr_index], wr_word, wr_data);
        end else begin
            valid_d = valid_q;
        end
    end

    // Status bits are cleared on reset so all lines start invalid and clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data payload need no reset; Valid guards their use.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/datacache.sv
// Direct-mapped write-back, write-allocate data cache: miss FSM and the
// registered CPU/memory handshakes around datacache_array.
module datacache #(
    parameter int WORD_SIZE   = datacache_pkg::WORD_SIZE,
    parameter int BLOCK_SIZE  = datacache_pkg::BLOCK_SIZE,
    parameter int CACHE_GROUP = datacache_pkg::CACHE_GROUP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [WORD_SIZE-1:0]  cpu_addr,
    input  logic [WORD_SIZE-1:0]  cpu_wdata,
    output logic [WORD_SIZE-1:0]  cpu_rdata,
    output logic                  cpu_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [WORD_SIZE-1:0]  mem_addr,
    output logic [BLOCK_SIZE-1:0] mem_wdata,
    input  logic [BLOCK_SIZE-1:0] mem_rdata,
    input  logic                  mem_ack
);
    import datacache_pkg::*;

    state_e                  state_q, state_d;
    logic                    cpu_ready_q, cpu_ready_d;
    logic [WORD_SIZE-1:0]    cpu_rdata_q, cpu_rdata_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [WORD_SIZE-1:0]    mem_addr_q, mem_addr_d;
    logic [BLOCK_SIZE-1:0]   mem_wdata_q, mem_wdata_d;

    logic [CACHE_INDEX_LEN-1:0] cpu_index_s;
    logic [CACHE_TAG_LEN-1:0]   cpu_tag_s;
    logic [WORD_SEL_LEN-1:0]    cpu_word_s;
    logic [WORD_SIZE-1:0]       cpu_block_s;
    logic [1:0]                 addr_lsb_unused;
    logic                       rd_valid_s, rd_dirty_s, hit_s;
    logic [CACHE_TAG_LEN-1:0]   rd_tag_s;
    logic [BLOCK_SIZE-1:0]      rd_data_s;
    logic                       fill_en_s, wr_en_s;

    assign cpu_index_s     = cpu_addr[CACHE_OFFSET_LEN +: CACHE_INDEX_LEN];
    assign cpu_tag_s       = cpu_addr[WORD_SIZE-1 -: CACHE_TAG_LEN];
    assign cpu_word_s      = cpu_addr[2 +: WORD_SEL_LEN];
    assign cpu_block_s     = {cpu_addr[WORD_SIZE-1:CACHE_OFFSET_LEN], {CACHE_OFFSET_LEN{1'b0}}};
    assign addr_lsb_unused = cpu_addr[1:0];
    assign hit_s           = rd_valid_s && (rd_tag_s == cpu_tag_s);

    datacache_array #(.LINES(CACHE_GROUP)) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (cpu_index_s),
        .rd_valid   (rd_valid_s),
        .rd_dirty   (rd_dirty_s),
        .rd_tag     (rd_tag_s),
        .rd_data    (rd_data_s),
        .fill_en    (fill_en_s),
        .fill_index (cpu_index_s),
        .fill_tag   (cpu_tag_s),
        .fill_data  (mem_rdata),
        .wr_en      (wr_en_s),
        .wr_index   (cpu_index_s),
        .wr_word    (cpu_word_s),
        .wr_data    (cpu_wdata)
    );

    // Miss FSM; a request is only accepted once the previous ready pulse has gone.
    always_comb begin
        state_d     = state_q;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_en_s   = 1'b0;
        wr_en_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req && !cpu_ready_q) begin
                    if (hit_s) begin
                        cpu_ready_d = 1'b1;
                        if (cpu_we) begin
                            wr_en_s = 1'b1;
                        end else begin
                            cpu_rdata_d = line_word(rd_data_s, cpu_word_s);
                        end
                    end else if (rd_valid_s && rd_dirty_s) begin
                        state_d     = ST_WBACK;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {rd_tag_s, cpu_index_s, {CACHE_OFFSET_LEN{1'b0}}};
                        mem_wdata_d = rd_data_s;
                    end else begin
                        state_d    = ST_REFILL;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = cpu_block_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WBACK: begin
                if (mem_ack) begin
                    state_d    = ST_REFILL;
                    mem_we_d   = 1'b0;
                    mem_addr_d = cpu_block_s;
                end else begin
                    state_d = ST_WBACK;
                end
            end
            ST_REFILL: begin
                if (mem_ack) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    fill_en_s = 1'b1;
                end else begin
                    state_d = ST_REFILL;
                end
            end
            ST_RESP: begin
                // The line was filled on the previous edge, so this is always a hit.
                state_d     = ST_IDLE;
                cpu_ready_d = 1'b1;
                if (cpu_we) begin
                    wr_en_s = 1'b1;
                end else begin
                    cpu_rdata_d = line_word(rd_data_s, cpu_word_s);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any miss in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/datacache.md
# datacache

Direct-mapped, write-back, write-allocate data cache for the bourgeois core's load/store unit. Sits between the memory stage and block-wide data memory, and is the read/write counterpart of the read-only instruction cache. It services 32-bit word loads and stores from the CPU side and issues whole-block refill reads and dirty-block write-backs to memory over a request/acknowledge handshake.

## Interface
Parameters:
- `WORD_SIZE`, 32, CPU address and data width
- `BLOCK_SIZE`, 256, line width in bits (32 bytes)
- `CACHE_GROUP`, 8, number of lines

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `cpu_req`  in  1  access request; held until `cpu_ready`
- `cpu_we`  in  1  1 = store, 0 = load
- `cpu_addr`  in  32  byte address; offset [4:0], index [7:5], tag [31:8]; [1:0] ignored
- `cpu_wdata`  in  32  store data
- `cpu_rdata`  out  32  load data, valid while `cpu_ready`=1
- `cpu_ready`  out  1  one-cycle completion pulse
- `mem_req`  out  1  memory request, held until `mem_ack`
- `mem_we`  out  1  1 = write-back, 0 = refill read
- `mem_addr`  out  32  block-aligned address ([4:0]=0)
- `mem_wdata`  out  256  victim line for write-back
- `mem_rdata`  in  256  refill line, sampled on the `mem_ack` edge
- `mem_ack`  in  1  one-cycle completion from memory

## Operation
- Per line: Valid, Dirty, 24-bit Tag, 256-bit Data. Word w = offset[4:2] occupies Data bits [w*32+31 : w*32], byte 0 at LSB.
- States: IDLE, WBACK, REFILL, RESP.
- IDLE: `cpu_req`=0 -> stay. Hit (Valid and Tag match) -> load: latch word into `cpu_rdata`; store: write word, set Dirty; pulse `cpu_ready`; stay IDLE. Miss with clean or invalid victim -> REFILL. Miss with Valid and Dirty victim -> WBACK.
- WBACK: `mem_req`=1, `mem_we`=1, `mem_addr`={victim Tag, index, 5'b0}, `mem_wdata`=victim Data. On `mem_ack` -> REFILL.
- REFILL: `mem_req`=1, `mem_we`=0, `mem_addr`={cpu_addr[31:5], 5'b0}. On `mem_ack`: Data<=`mem_rdata`, Tag<=new tag, Valid<=1, Dirty<=0 -> RESP.
- RESP: re-run as a hit (guaranteed): perform load/store, pulse `cpu_ready`, -> IDLE.
- `cpu_addr`, `cpu_we`, `cpu_wdata` must remain stable from request until `cpu_ready`; the cache does not latch them.
- `mem_ack` outside WBACK/REFILL is ignored. `cpu_req` dropping mid-miss is a protocol violation; the miss still completes and the line is filled.

## Timing
- Reset: state=IDLE; all Valid and Dirty cleared; `cpu_ready`=0, `cpu_rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-miss: abort immediately, `mem_req` low in the next cycle, dirty data is discarded (not written back).
- Hit latency: `cpu_req` sampled at edge N -> `cpu_ready`=1 and `cpu_rdata` valid during cycle N+1. Back-to-back hits sustain one access every 2 cycles (request is re-sampled only after `cpu_ready` drops).
- Clean miss: `mem_req` rises in cycle N+1; with `mem_ack` at edge M, `cpu_ready` pulses in cycle M+2 (RESP at M+1, pulse registered at M+2).
- Dirty miss: adds one WBACK handshake; `mem_req` stays high across WBACK->REFILL, and `mem_we` and `mem_addr` switch on the ack edge.
- All outputs are registered; no combinational CPU-to-memory path.

## Structure
- `define.v` holds `WORD_SIZE`, `BLOCK_SIZE`, `BYTE_SIZE`, `CACHE_GROUP`, `CACHE_OFFSET_LEN`(5), `CACHE_INDEX_LEN`(3), `CACHE_TAG_LEN`(24), and the state encodings.
- Sub-module `datacache_array`: Valid/Dirty/Tag/Data storage, a read port by index, a line-fill port, and a word-write port with a Dirty set. `datacache` contains the FSM and handshake logic only.

## Test plan
- After reset, load 0x0000_0100 -> WBACK skipped, REFILL `mem_addr`=0x100; respond with a line whose word 0 is 0xDEADBEEF -> `cpu_rdata`=0xDEADBEEF, `cpu_ready` a single pulse.
- Repeat the load from 0x104 -> hit, no `mem_req`, `cpu_ready` in the next cycle with word 1 of the line.
- Store 0x12345678 to 0x108 (hit), then load 0x2108 (same index, different tag) -> WBACK to 0x100 whose `mem_wdata` word 2 = 0x12345678, then REFILL 0x2100.
- Delay `mem_ack` 10 cycles -> `mem_req`, `mem_addr`, `mem_we` stable throughout; stray `mem_ack` while in IDLE -> no state change.
- Assert `rst` during REFILL -> `mem_req`=0 next cycle; a subsequent load of the same address misses again.
- Fill all 8 indices, then reload each -> 8 hits with zero memory traffic.
